// File: rtl/c17_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// c17_bist_ctrl_if
// Handshake/result bundle for the c17 BIST controller.
//   start    : single-cycle request to begin a self-test run
//   abort    : cancels an active run
//   exp_sig  : golden signature compared against the MISR at the end of a run
//   busy     : controller is initialising, running or checking
//   done     : run finished; pass/sig are stable while this is high
//   pass     : final signature matched exp_sig
//   sig      : current MISR contents
//   pat_cnt  : patterns applied in the current run
// The master side issues requests and reads status; the slave is the controller.
// -----------------------------------------------------------------------------
interface c17_bist_ctrl_if;
   logic       start;
   logic       abort;
   logic [7:0] exp_sig;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] sig;
   logic [7:0] pat_cnt;

   modport master (
      output start, abort, exp_sig,
      input  busy, done, pass, sig, pat_cnt
   );

   modport slave (
      input  start, abort, exp_sig,
      output busy, done, pass, sig, pat_cnt
   );
endinterface

// File: rtl/c17_bist_ctrl.sv
// -----------------------------------------------------------------------------
// c17_bist_ctrl
// BIST controller for a single combinational c17 instance. Patterns come from
// a 5-bit LFSR (x^5+x^3+1), responses N22/N23 are compacted into an 8-bit MISR
// and the final signature is compared against a golden value.
//
// Ports:
//   CK                   clock, rising edge
//   RST                  synchronous active-high reset
//   bus                  c17_bist_ctrl_if.slave (start/abort/exp_sig in,
//                        busy/done/pass/sig/pat_cnt out)
//   N1,N2,N3,N6,N7       pattern to the CUT (N1 = pat[4] ... N7 = pat[0])
//   N22,N23              CUT responses, valid in the same cycle as the pattern
//
// Build option: define C17_BIST_EXHAUSTIVE_EN to replace the LFSR with a 5-bit
// binary counter starting at 0 and apply all 32 input combinations.
// -----------------------------------------------------------------------------
module c17_bist_ctrl #(
   parameter int         NUM_PATTERNS = 31,
   parameter logic [4:0] SEED         = 5'b00001,
   parameter int         SIG_W        = 8
) (
   input  logic          CK,
   input  logic          RST,
   c17_bist_ctrl_if.slave bus,
   output logic          N1,
   output logic          N2,
   output logic          N3,
   output logic          N6,
   output logic          N7,
   input  logic          N22,
   input  logic          N23
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_INIT  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

`ifdef C17_BIST_EXHAUSTIVE_EN
   localparam logic [7:0] LAST_CNT = 8'd31;
   localparam logic [4:0] PAT_INIT = 5'd0;
`else
   localparam logic [7:0] LAST_CNT = 8'(NUM_PATTERNS - 1);
   localparam logic [4:0] PAT_INIT = SEED;
`endif

   logic [2:0]       state_q, state_d;
   logic [4:0]       pat_q, pat_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             start_q, start_d;
   logic             busy;
   logic [4:0]       pat_step;
   logic [SIG_W-1:0] sig_step;

   assign busy = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_CHECK);

   // Next pattern and next signature for one RUN cycle.
   always_comb begin
`ifdef C17_BIST_EXHAUSTIVE_EN
      pat_step = pat_q + 5'd1;
`else
      pat_step = {pat_q[3:0], pat_q[4] ^ pat_q[2]};
`endif
      sig_step = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? SIG_W'(8'h1D) : '0)
               ^ SIG_W'({N22, N23});
   end

   // Sequencer. start is registered once (and dropped while busy) so a request
   // reaches the FSM one cycle after it is sampled; abort overrides all RUN
   // work and leaves sig/pat_cnt untouched for debug.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      start_d = bus.start & ~busy;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_q) state_d = ST_INIT;
         end
         ST_INIT: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               pat_d   = PAT_INIT;
               sig_d   = '0;
               cnt_d   = 8'd0;
               pass_d  = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               sig_d = sig_step;
               pat_d = pat_step;
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               if (cnt_q == LAST_CNT) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               pass_d  = (sig_q == SIG_W'(bus.exp_sig));
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         pat_q   <= 5'd0;
         sig_q   <= '0;
         cnt_q   <= 8'd0;
         pass_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         start_q <= start_d;
      end
   end

   assign {N1, N2, N3, N6, N7} = pat_q;
   assign bus.busy    = busy;
   assign bus.done    = (state_q == ST_DONE);
   assign bus.pass    = pass_q;
   assign bus.sig     = 8'(sig_q);
   assign bus.pat_cnt = cnt_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_c17_bist_ctrl
// Drives two controllers (default parameters, and NUM_PATTERNS=1) each wired
// to a behavioural c17. Expected patterns and final signatures come from a
// reference LFSR/c17/MISR model and are queued when a run is started, then
// popped as the controller produces them.
// -----------------------------------------------------------------------------
module tb_c17_bist_ctrl;

`ifdef C17_BIST_EXHAUSTIVE_EN
   localparam int         NP0      = 32;
   localparam int         NP1      = 32;
   localparam logic [4:0] SEED_EFF = 5'd0;
`else
   localparam int         NP0      = 31;
   localparam int         NP1      = 1;
   localparam logic [4:0] SEED_EFF = 5'd1;
`endif

   logic CK = 1'b0;
   logic RST;
   always #5 CK = ~CK;

   c17_bist_ctrl_if b0();
   c17_bist_ctrl_if b1();

   logic n1_0, n2_0, n3_0, n6_0, n7_0, n22_0, n23_0;
   logic n1_1, n2_1, n3_1, n6_1, n7_1, n22_1, n23_1;

   int n_vec = 0;
   int n_err = 0;

   logic [4:0] pat_q[$];
   logic [7:0] sig_q[$];
   logic       pass_q[$];

   // Gate-level c17 reference: NAND network N10..N23.
   function automatic logic [1:0] ref_c17(input logic [4:0] p);
      logic a1, a2, a3, a6, a7, g10, g11, g16, g19;
      {a1, a2, a3, a6, a7} = p;
      g10 = ~(a1 & a3);
      g11 = ~(a3 & a6);
      g16 = ~(a2 & g11);
      g19 = ~(g11 & a7);
      return {~(g10 & g16), ~(g16 & g19)};
   endfunction

   function automatic logic [4:0] ref_next_pat(input logic [4:0] p);
`ifdef C17_BIST_EXHAUSTIVE_EN
      return p + 5'd1;
`else
      return {p[3:0], p[4] ^ p[2]};
`endif
   endfunction

   function automatic logic [7:0] ref_misr(input logic [7:0] s, input logic [1:0] r);
      return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
   endfunction

   function automatic logic [7:0] ref_run(input int np);
      logic [4:0] p;
      logic [7:0] s;
      p = SEED_EFF;
      s = 8'h00;
      for (int k = 0; k < np; k++) begin
         s = ref_misr(s, ref_c17(p));
         p = ref_next_pat(p);
      end
      return s;
   endfunction

   assign {n22_0, n23_0} = ref_c17({n1_0, n2_0, n3_0, n6_0, n7_0});
   assign {n22_1, n23_1} = ref_c17({n1_1, n2_1, n3_1, n6_1, n7_1});

   c17_bist_ctrl dut0 (
      .CK(CK), .RST(RST), .bus(b0.slave),
      .N1(n1_0), .N2(n2_0), .N3(n3_0), .N6(n6_0), .N7(n7_0),
      .N22(n22_0), .N23(n23_0)
   );

   c17_bist_ctrl #(.NUM_PATTERNS(1), .SEED(5'b00001)) dut1 (
      .CK(CK), .RST(RST), .bus(b1.slave),
      .N1(n1_1), .N2(n2_1), .N3(n3_1), .N6(n6_1), .N7(n7_1),
      .N22(n22_1), .N23(n23_1)
   );

   // Observation mux selecting which controller the current step looks at.
   logic sel;
   wire       o_busy = sel ? b1.busy    : b0.busy;
   wire       o_done = sel ? b1.done    : b0.done;
   wire       o_pass = sel ? b1.pass    : b0.pass;
   wire [7:0] o_sig  = sel ? b1.sig     : b0.sig;
   wire [7:0] o_cnt  = sel ? b1.pat_cnt : b0.pat_cnt;
   wire [4:0] o_pat  = sel ? {n1_1, n2_1, n3_1, n6_1, n7_1} : {n1_0, n2_0, n3_0, n6_0, n7_0};

   task automatic tick;
      @(posedge CK);
      @(negedge CK);
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bit s, input logic st, input logic ab, input logic [7:0] es);
      if (s) begin
         b1.start = st; b1.abort = ab; b1.exp_sig = es;
      end else begin
         b0.start = st; b0.abort = ab; b0.exp_sig = es;
      end
   endtask

   // One complete run with pattern-by-pattern and end-of-run checking.
   // extra_k > 0 pulses start during that RUN cycle (must be ignored);
   // with_abort raises abort together with start while idle (start wins).
   task automatic do_run(input bit s, input logic [7:0] es, input int np, input int extra_k,
                         input bit with_abort, output logic [31:0] seen, output int dups);
      logic [4:0] p;
      logic [7:0] sg;
      logic [4:0] exp_p;
      p  = SEED_EFF;
      sg = 8'h00;
      for (int k = 0; k < np; k++) begin
         pat_q.push_back(p);
         sg = ref_misr(sg, ref_c17(p));
         p  = ref_next_pat(p);
      end
      sig_q.push_back(sg);
      pass_q.push_back(sg == es);
      sel = s;
      apply_stimulus(s, 1'b1, with_abort, es);
      tick;
      apply_stimulus(s, 1'b0, 1'b0, es);
      tick;
      check_output("init_busy", o_busy, 1);
      tick;
      seen = 0;
      dups = 0;
      for (int k = 1; k <= np; k++) begin
         exp_p = pat_q.pop_front();
         check_output("run_pat", o_pat, exp_p);
         check_output("run_cnt", o_cnt, k - 1);
         if (seen[o_pat]) dups++;
         seen[o_pat] = 1'b1;
         if (k == extra_k) apply_stimulus(s, 1'b1, 1'b0, es);
         tick;
         apply_stimulus(s, 1'b0, 1'b0, es);
      end
      check_output("check_busy", o_busy, 1);
      check_output("check_not_done", o_done, 0);
      check_output("check_pat_frozen", o_pat, p);
      tick;
      check_output("done_rise", o_done, 1);
      check_output("done_busy", o_busy, 0);
      check_output("done_sig", o_sig, sig_q.pop_front());
      check_output("done_pass", o_pass, pass_q.pop_front());
      check_output("done_cnt", o_cnt, np);
      tick;
      tick;
      check_output("done_hold", o_done, 1);
      check_output("done_hold_sig", o_sig, sg);
      check_output("done_hold_pat", o_pat, p);
   endtask

   initial begin
      logic [31:0] seen;
      int          dups;
      logic [7:0]  golden;

      golden = ref_run(NP0);
      sel = 1'b0;
      RST = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);

      // Reset held two cycles with start high.
      tick;
      tick;
      check_output("rst_busy", o_busy, 0);
      check_output("rst_done", o_done, 0);
      check_output("rst_pass", o_pass, 0);
      check_output("rst_sig", o_sig, 8'h00);
      check_output("rst_pat", o_pat, 5'd0);
      check_output("rst_cnt", o_cnt, 8'd0);
      RST = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
      tick;
      tick;
      check_output("idle_after_rst", o_busy, 0);

      // Single-pattern run, matching and mismatching golden signature.
      do_run(1'b1, 8'h01, NP1, 0, 1'b0, seen, dups);
`ifndef C17_BIST_EXHAUSTIVE_EN
      check_output("t2_sig_const", o_sig, 8'h01);
      check_output("t2_pass_const", o_pass, 1);
`endif
      do_run(1'b1, 8'h02, NP1, 0, 1'b0, seen, dups);
`ifndef C17_BIST_EXHAUSTIVE_EN
      check_output("t3_pass_const", o_pass, 0);
`endif

      // Full default run: every pattern visited exactly once.
      do_run(1'b0, golden, NP0, 0, 1'b0, seen, dups);
`ifdef C17_BIST_EXHAUSTIVE_EN
      check_output("t4_seen", seen, 32'hFFFF_FFFF);
`else
      check_output("t4_seen", seen, 32'hFFFF_FFFE);
`endif
      check_output("t4_dups", dups, 0);

      // Abort in the 5th RUN cycle.
      sel = 1'b0;
      apply_stimulus(1'b0, 1'b1, 1'b0, golden);
      tick;
      apply_stimulus(1'b0, 1'b0, 1'b0, golden);
      tick;
      tick;
      tick;
      tick;
      tick;
      tick;
      check_output("abort_pre_cnt", o_cnt, 8'd4);
      apply_stimulus(1'b0, 1'b0, 1'b1, golden);
      tick;
      apply_stimulus(1'b0, 1'b0, 1'b0, golden);
      check_output("abort_busy", o_busy, 0);
      check_output("abort_done", o_done, 0);
      check_output("abort_pass", o_pass, 0);
      tick;
      check_output("abort_stay_idle", o_busy, 0);

      // Restart after abort with start and abort together while idle.
      do_run(1'b0, golden, NP0, 0, 1'b1, seen, dups);

      // Start pulsed in RUN cycle 3 is ignored; timing unchanged.
      do_run(1'b0, golden, NP0, 3, 1'b0, seen, dups);

      // Reset in the middle of a run.
      sel = 1'b0;
      apply_stimulus(1'b0, 1'b1, 1'b0, golden);
      tick;
      apply_stimulus(1'b0, 1'b0, 1'b0, golden);
      tick;
      tick;
      tick;
      tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      check_output("midrst_busy", o_busy, 0);
      check_output("midrst_done", o_done, 0);
      check_output("midrst_pass", o_pass, 0);
      check_output("midrst_sig", o_sig, 8'h00);
      check_output("midrst_cnt", o_cnt, 8'd0);
      check_output("midrst_pat", o_pat, 5'd0);
      tick;
      check_output("midrst_idle", o_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
Built-in self-test controller that sequences one c17 gate-level instance (the CUT) for fault-coverage and fault-collapsing experiments. It generates patterns on N1,N2,N3,N6,N7 with a 5-bit LFSR and compacts the N22/N23 responses into a MISR signature. It also compares the final signature against an expected value and reports pass/fail through a start/busy/done handshake.

Parameters:
NUM_PATTERNS, 31, patterns applied per run; legal range 1..255.
SEED, 5'b00001, LFSR seed; must be nonzero.
SIG_W, 8, MISR width; fixed at 8 for the polynomial defined below.

Ports:
CK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
start  input  1  single-cycle request to begin a run
abort  input  1  cancels an active run
exp_sig  input  8  expected golden signature; sampled in CHECK
N1,N2,N3,N6,N7  output  1 each  pattern driven to the CUT: N1=pat[4], N2=pat[3], N3=pat[2], N6=pat[1], N7=pat[0]
N22,N23  input  1 each  CUT responses
busy  output  1  high in INIT, RUN and CHECK
done  output  1  high in DONE
pass  output  1  sig==exp_sig latched in CHECK; valid only while done=1
sig  output  8  current MISR contents
pat_cnt  output  8  patterns applied in the current run

Behaviour:
- Reset (RST=1 at a CK edge): state=IDLE, pat=0, sig=0, pat_cnt=0, busy=0, done=0, pass=0. Reset takes priority over every input, including mid-run.
- IDLE: start=1 -> INIT.
- DONE: start=1 -> INIT. Otherwise DONE holds, with done, pass and sig stable.
- INIT (1 cycle): pat<=SEED, sig<=0, pat_cnt<=0, pass<=0; then -> RUN.
- RUN: the CUT is combinational, so the response to pat is valid in the same cycle.
  - Each RUN cycle: sig<=misr(sig,{N22,N23}), pat<=lfsr(pat), pat_cnt<=pat_cnt+1.
  - When pat_cnt==NUM_PATTERNS-1 in that cycle -> CHECK. Exactly NUM_PATTERNS responses are compacted.
- lfsr: Fibonacci form, polynomial x^5+x^3+1. next = {pat[3:0], pat[4]^pat[2]}. Period is 31 and it never reaches 0.
- misr: next = {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {6'b0, N22, N23}.
- CHECK (1 cycle): pass<=(sig==exp_sig); pat and sig freeze; then -> DONE.
- Timing: done rises on the edge NUM_PATTERNS+3 cycles after the edge that samples start.
- start while busy=1 is ignored.
- abort=1 in INIT, RUN or CHECK -> IDLE with done=0 and pass=0. sig and pat_cnt keep their partial values for debug. abort in IDLE or DONE has no effect.
- start and abort high together:
  - While busy: abort wins.
  - In IDLE or DONE: start wins.
- pat holds its value in IDLE, CHECK and DONE.
- pat_cnt saturates at 255. It never exceeds NUM_PATTERNS in normal operation.

Optional Feature:
C17_BIST_EXHAUSTIVE_EN
- Defined: the LFSR is replaced by a 5-bit binary counter. INIT loads pat<=0, and RUN increments pat modulo 32. NUM_PATTERNS is forced to 32 inside the block, so all 32 input combinations, including 00000, are applied. Everything else is unchanged.
- Undefined: LFSR operation as specified above.

Test Plan:
1. Hold RST=1 for 2 cycles with start=1 -> busy=0, done=0, pass=0, sig=8'h00, pat=0, state IDLE after release.
2. NUM_PATTERNS=1, SEED=5'b00001, exp_sig=8'h01, pulse start -> expected response:
   - pattern N7=1, all other inputs 0 -> N22=0, N23=1;
   - sig=8'h01;
   - done rises 4 cycles after start sampled, with pass=1.
3. Same run with exp_sig=8'h02 -> done=1, pass=0, sig=8'h01.
4. Default parameters -> over the 31 RUN cycles pat visits every nonzero value exactly once, pat_cnt=31 at done, and sig matches the bench's reference model of c17 plus the MISR.
5. Assert abort in the 5th RUN cycle -> next cycle busy=0, done=0, state IDLE. A following start runs a full run and gives the same sig as test 4.
6. Pulse start during RUN -> ignored, with timing identical to test 4. Assert RST mid-RUN -> all outputs return to reset values on the next edge. With C17_BIST_EXHAUSTIVE_EN defined, pat steps through 0..31 and done rises 35 cycles after start sampled.
